// File: rtl/mem_mmio.sv
// Processor-side memory map: word RAM, free-running cycle counter and a byte TX FIFO
// with status. Loads are combinational so the core samples them on the same edge.
module mem_mmio #(
   parameter int unsigned RAM_WORDS  = 64,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] adr,
   input  logic [31:0] writedata,
   input  logic        memwrite,
   output logic [31:0] readdata,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready
);

   localparam int unsigned AW = $clog2(RAM_WORDS);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;

   localparam logic [31:0] ADR_CNT  = 32'hFFFF_FFF0;
   localparam logic [31:0] ADR_STAT = 32'hFFFF_FFF4;
   localparam logic [31:0] ADR_TXD  = 32'hFFFF_FFF8;

   logic          ram_sel, cnt_sel, stat_sel, txd_sel;
   logic [AW-1:0] ram_idx;

   logic [31:0]   ram_q [RAM_WORDS];
   logic [7:0]    fifo_q [FIFO_DEPTH];

   logic [31:0]   cnt_q, cnt_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;

   logic          full, empty, push, pop;
   logic [31:0]   stat_word;

   // Address decode; RAM aliases across the low 64 KiB
   assign ram_sel  = (adr[31:16] == 16'd0);
   assign cnt_sel  = (adr == ADR_CNT);
   assign stat_sel = (adr == ADR_STAT);
   assign txd_sel  = (adr == ADR_TXD);
   assign ram_idx  = adr[AW+1:2];

   assign full      = (count_q == CW'(FIFO_DEPTH));
   assign empty     = (count_q == CW'(0));
   assign out_valid = ~empty;
   assign out_data  = fifo_q[rd_ptr_q];

   // A push into a full FIFO is accepted only when the head leaves in the same cycle
   assign pop  = out_valid & out_ready;
   assign push = memwrite & txd_sel & (~full | pop);

   assign stat_word = {21'd0, ovf_q, empty, full, 8'(count_q)};

   always_ff @(posedge clk) begin
      if (memwrite && ram_sel) begin
         ram_q[ram_idx] <= writedata;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= writedata[7:0];
      end
   end

   always_comb begin
      cnt_d    = cnt_q + 32'd1;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
      ovf_d    = ovf_q;

      if (memwrite && cnt_sel) begin
         cnt_d = writedata;
      end
      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (memwrite && stat_sel) begin
         ovf_d = 1'b0;
      end else if (memwrite && txd_sel && full && !pop) begin
         ovf_d = 1'b1;
      end
   end

   // Reset takes priority over any same-cycle MMIO write and discards queued bytes
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q    <= 32'd0;
         wr_ptr_q <= PW'(0);
         rd_ptr_q <= PW'(0);
         count_q  <= CW'(0);
         ovf_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   always_comb begin
      readdata = 32'd0;
      if (ram_sel) begin
         readdata = ram_q[ram_idx];
      end else if (cnt_sel) begin
         readdata = cnt_q;
      end else if (stat_sel) begin
         readdata = stat_word;
      end
   end

endmodule

// File: tb/tb_mem_mmio.sv
// Scoreboard bench for mem_mmio: stimulus queues expected loads and TX bytes,
// a negedge monitor pops and compares them as the DUT presents data.
module tb_mem_mmio;

   localparam logic [31:0] A_CNT  = 32'hFFFF_FFF0;
   localparam logic [31:0] A_STAT = 32'hFFFF_FFF4;
   localparam logic [31:0] A_TXD  = 32'hFFFF_FFF8;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] adr;
   logic [31:0] writedata;
   logic        memwrite;
   logic [31:0] readdata;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;

   mem_mmio #(.RAM_WORDS(64), .FIFO_DEPTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .adr       (adr),
      .writedata (writedata),
      .memwrite  (memwrite),
      .readdata  (readdata),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      int          kind;
      logic [31:0] exp;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] tx_q[$];
   int         n_chk  = 0;
   int         n_pass = 0;
   logic       req    = 1'b0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endfunction

   // Monitor: kind 0 compares readdata, kind 1 compares out_valid
   always @(negedge clk) begin
      exp_t       e;
      logic [7:0] b;
      if (req) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL scoreboard_underflow: load presented with no expectation queued");
         end else begin
            e = exp_q.pop_front();
            check(e.name, (e.kind == 0) ? readdata : {31'd0, out_valid}, e.exp);
         end
      end
      if (out_valid && out_ready) begin
         if (tx_q.size() == 0) begin
            n_chk++;
            $display("FAIL tx_unexpected: got 0x%02h with no byte expected", out_data);
         end else begin
            b = tx_q.pop_front();
            check("tx_byte", 32'(out_data), 32'(b));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      req = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] x, input string nm);
      adr      = a;
      memwrite = 1'b0;
      exp_q.push_back('{nm, 0, x});
      req = 1'b1;
      step();
   endtask

   task automatic vchk(input logic x, input string nm);
      exp_q.push_back('{nm, 1, {31'd0, x}});
      req = 1'b1;
      step();
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      adr       = a;
      writedata = d;
      memwrite  = 1'b1;
      step();
      memwrite  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] bytes [5];
      bytes = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};

      reset     = 1'b0;
      adr       = 32'd0;
      writedata = 32'd0;
      memwrite  = 1'b0;
      out_ready = 1'b0;

      // Reset state, held low
      step();
      rd(A_STAT, 32'h200, "rst_stat");
      rd(A_CNT, 32'd0, "rst_cnt");
      vchk(1'b0, "rst_out_valid");
      reset = 1'b1;

      // RAM write and alias read
      wr(32'h10, 32'hDEAD_BEEF);
      rd(32'h10, 32'hDEAD_BEEF, "ram_rd");
      rd(32'h110, 32'hDEAD_BEEF, "ram_alias");
      rd(32'h13, 32'hDEAD_BEEF, "ram_low_bits_ignored");

      // Counter count-up, load and wrap
      reset = 1'b0;
      step();
      reset = 1'b1;
      repeat (5) step();
      rd(A_CNT, 32'd5, "cnt_after_5");
      wr(A_CNT, 32'hFFFF_FFFE);
      rd(A_CNT, 32'hFFFF_FFFE, "cnt_loaded");
      rd(A_CNT, 32'hFFFF_FFFF, "cnt_plus1");
      rd(A_CNT, 32'h0000_0000, "cnt_wrap");

      // Fill past full with consumer stalled
      for (int i = 0; i < 5; i++) begin
         if (i < 4) tx_q.push_back(bytes[i]);
         wr(A_TXD, {24'd0, bytes[i]});
      end
      rd(A_STAT, 32'h504, "stat_full_ovf");
      vchk(1'b1, "valid_when_full");
      wr(A_STAT, 32'hFFFF_FFFF);
      rd(A_STAT, 32'h104, "stat_ovf_cleared");
      rd(A_TXD, 32'd0, "txd_reads_zero");

      // Simultaneous push and pop while full
      out_ready = 1'b1;
      tx_q.push_back(8'h55);
      wr(A_TXD, 32'h55);
      out_ready = 1'b0;
      rd(A_STAT, 32'h104, "stat_push_pop_full");
      out_ready = 1'b1;
      for (int i = 0; i < 20 && out_valid; i++) step();
      out_ready = 1'b0;
      check("drain_complete", 32'(tx_q.size()), 32'd0);
      rd(A_STAT, 32'h200, "stat_drained");

      // Reset during a pop flushes the FIFO
      wr(A_TXD, 32'h61);
      vchk(1'b1, "valid_after_push");
      tx_q.push_back(8'h61);
      out_ready = 1'b1;
      reset     = 1'b0;
      step();
      reset     = 1'b1;
      out_ready = 1'b0;
      vchk(1'b0, "valid_after_reset");
      rd(A_STAT, 32'h200, "stat_after_reset");
      rd(32'h10, 32'hDEAD_BEEF, "ram_survives_reset");

      // Reset overrides same-cycle MMIO writes
      wr(A_TXD, 32'h70);
      adr = A_TXD; writedata = 32'h77; memwrite = 1'b1; reset = 1'b0;
      step();
      memwrite = 1'b0; reset = 1'b1;
      rd(A_STAT, 32'h200, "rst_overrides_txd");
      adr = A_CNT; writedata = 32'h1234; memwrite = 1'b1; reset = 1'b0;
      step();
      memwrite = 1'b0; reset = 1'b1;
      rd(A_CNT, 32'd0, "rst_overrides_cnt");

      // Unmapped addresses
      wr(32'h0, 32'h1111_1111);
      wr(A_CNT, 32'd100);
      wr(32'h0002_0000, 32'hCAFE_F00D);
      wr(32'hFFFF_FFFC, 32'hAB);
      rd(A_CNT, 32'd102, "cnt_unaffected");
      rd(32'h0002_0000, 32'd0, "unmapped_rd_20000");
      rd(32'hFFFF_FFFC, 32'd0, "unmapped_rd_fffc");
      rd(32'h0, 32'h1111_1111, "ram_unaffected");
      rd(A_STAT, 32'h200, "fifo_unaffected");

      step();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_mmio.md
MEM_MMIO -- requirements
Module: mem_mmio

Interface
REQ-001 The block SHALL have parameter RAM_WORDS, default 64, giving the number of 32-bit RAM words (power of 2).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the number of TX FIFO entries (power of 2, at least 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port adr, input, 32 bits: byte address from the processor.
REQ-006 The block SHALL have port writedata, input, 32 bits: store data from the processor.
REQ-007 The block SHALL have port memwrite, input, 1 bit: store strobe, 1 = write this cycle.
REQ-008 The block SHALL have port readdata, output, 32 bits: load/fetch data to the processor.
REQ-009 The block SHALL have port out_data, output, 8 bits: TX FIFO head byte.
REQ-010 The block SHALL have port out_valid, output, 1 bit: FIFO non-empty.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the head byte when it and out_valid are both 1.

Function
REQ-012 The block SHALL decode RAM when adr[31:16]==0; word index = adr[log2(RAM_WORDS)+1:2]; higher bits alias; adr[1:0] ignored.
REQ-013 The block SHALL decode MMIO registers: CNT at 0xFFFFFFF0, STAT at 0xFFFFFFF4, TXD at 0xFFFFFFF8.
REQ-014 For any other address, reads SHALL return 0 and writes SHALL be ignored.
REQ-015 readdata SHALL be combinational from adr and current state, with zero-cycle latency, so that the processor samples it at the same rising edge.
REQ-016 A RAM write SHALL occur at the rising edge when memwrite=1; a read of that word in the following cycle SHALL return the new value.
REQ-017 CNT SHALL be a 32-bit free-running counter, +1 every cycle, wrapping 0xFFFFFFFF->0.
REQ-018 A write to CNT SHALL load writedata (no increment that cycle); CNT SHALL resume incrementing from the loaded value next cycle.
REQ-019 STAT reads SHALL return: [7:0] FIFO count, [8] full, [9] empty, [10] sticky overflow, others 0.
REQ-020 A write to STAT SHALL clear overflow (writedata ignored); all other STAT bits are read-only.
REQ-021 A write to TXD SHALL push writedata[7:0] when the FIFO is not full; TXD reads SHALL return 0.
REQ-022 A TXD write while full with no pop that cycle SHALL be dropped and SHALL set overflow.
REQ-023 Pop SHALL occur when out_valid & out_ready; out_data SHALL be the head entry; out_valid SHALL equal !empty.
REQ-024 Push and pop in the same cycle while full SHALL both be accepted; count SHALL be unchanged and overflow SHALL NOT be set.
REQ-025 A push while empty SHALL NOT pop that cycle; out_valid SHALL rise in the next cycle.
REQ-026 Read/write pointers SHALL wrap modulo FIFO_DEPTH; FIFO order SHALL be strictly preserved.
REQ-027 A STAT write and a TXD overflow in the same cycle are impossible (one address per cycle).

Reset
REQ-028 When reset=0 at a rising edge: CNT=0, FIFO count=0, pointers=0, overflow=0; out_valid SHALL be 0 from the next cycle.
REQ-029 RAM contents SHALL NOT be altered by reset.
REQ-030 Assertion of reset mid-operation SHALL flush the FIFO (queued bytes are discarded) and SHALL override any same-cycle write to CNT, STAT or TXD.
REQ-031 While reset=0, readdata SHALL still reflect the RAM/decode as specified; MMIO reads SHALL reflect reset values after the edge.

Verification
REQ-032 Write 0xDEADBEEF to adr 0x10, then read 0x10 and 0x110 (alias, RAM_WORDS=64) -> both return 0xDEADBEEF.
REQ-033 Reset, release, read CNT 5 cycles later -> 5; write 0xFFFFFFFE, read 2 cycles later -> 0x00000000 (wrapped).
REQ-034 out_ready=0, push 0x41,0x42,0x43,0x44,0x45 -> STAT=0x500 | 0x004 (full, overflow, count 4); write STAT -> overflow clears.
REQ-035 Full FIFO, out_ready=1 with simultaneous TXD write 0x55 -> count stays 4, overflow stays 0, drained order is 0x42,0x43,0x44,0x55 after head 0x41.
REQ-036 Push 0x61, then pull reset low for one cycle during the pop -> out_valid=0, STAT=0x200 after reset; the RAM word written earlier still reads back intact.
REQ-037 Read 0x00020000 and 0xFFFFFFFC, write to both -> reads return 0; RAM, CNT and FIFO are unaffected.
